// File: rtl/psum_wb_pkg.sv
// Shared constants and helpers for the partial-sum writeback stage.
// Holds the mode encodings, default widths and the signed saturation helper.
package psum_wb_pkg;

    localparam int WB_NUM_BANK  = 32;
    localparam int WB_BIT_PSUM  = 32;
    localparam int WB_BIT_OUT   = 16;
    localparam int WB_DEPTH     = 8;
    localparam int WB_BIT_SHIFT = 5;

    // Internal width of the saturation helper; BIT_PSUM must not exceed it.
    localparam int WB_SAT_W = 64;

    localparam logic [1:0] WB_MODE_SAT  = 2'b00;
    localparam logic [1:0] WB_MODE_RELU = 2'b01;
    localparam logic [1:0] WB_MODE_RAW  = 2'b10;

    // Clamp a signed value into the range representable in bit_out bits.
    function automatic logic signed [WB_SAT_W-1:0] saturate(
        input logic signed [WB_SAT_W-1:0] value,
        input int                         bit_out
    );
        logic signed [WB_SAT_W-1:0] hi;
        logic signed [WB_SAT_W-1:0] lo;
        hi = (WB_SAT_W'(1) <<< (bit_out - 1)) - WB_SAT_W'(1);
        lo = -hi - WB_SAT_W'(1);
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/psum_wb_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push on a full FIFO is only taken when a pop happens in the same cycle.
module psum_wb_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Push,
    input  logic              i_Pop,
    input  logic [DATA_W-1:0] i_Data,
    output logic [DATA_W-1:0] o_Data,
    output logic [CW-1:0]     o_Count,
    output logic              o_Full,
    output logic              o_Empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push_ok;
    logic              pop_ok;

    assign o_Full  = (count == CW'(DEPTH));
    assign o_Empty = (count == '0);
    assign o_Count = count;

    assign pop_ok  = i_Pop && !o_Empty;
    assign push_ok = i_Push && (!o_Full || pop_ok);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // NOTE: storage is not reset; the empty flag masks stale contents on the output.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_Data;
        end
    end

    assign o_Data = o_Empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/psum_wb_buf.sv
// Partial-sum writeback stage: one-hot bank select, requantisation and an FWFT
// output buffer drained over valid/ready, with sticky error flags and a beat counter.
module psum_wb_buf
    import psum_wb_pkg::*;
#(
    parameter int NUM_BANK  = WB_NUM_BANK,
    parameter int BIT_PSUM  = WB_BIT_PSUM,
    parameter int BIT_OUT   = WB_BIT_OUT,
    parameter int DEPTH     = WB_DEPTH,
    parameter int BIT_SHIFT = WB_BIT_SHIFT
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_BANK*BIT_PSUM-1:0] i_Psum,
    input  logic [NUM_BANK-1:0]          i_Psram_En,
    input  logic                         i_Valid_WB_Psum,
    input  logic [1:0]                   i_Mode,
    input  logic [BIT_SHIFT-1:0]         i_Shift,
    output logic                         o_Almost_Full,
    output logic [BIT_OUT-1:0]           o_Data_WB_Out,
    output logic                         o_Valid_WB_Psum,
    input  logic                         i_Ready,
    input  logic                         i_Err_Clr,
    output logic                         o_Err_Multi,
    output logic                         o_Err_Ovf,
    output logic [15:0]                  o_Beat_Cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [BIT_PSUM-1:0]        sel_psum;
    logic                       multi_hot;
    logic                       s1_valid;
    logic [BIT_PSUM-1:0]        s1_psum;
    logic [1:0]                 s1_mode;
    logic [BIT_SHIFT-1:0]       s1_shift;
    logic signed [BIT_PSUM-1:0] shifted;
    logic [BIT_OUT-1:0]         wb_data;
    logic [CW-1:0]              fifo_count;
    logic [CW-1:0]              count_nxt;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       push_acc;
    logic                       ovf_set;
    logic                       multi_set;
    logic                       af_nxt;

    // NOTE: always_comb blocks assign every output a default first so no latch is inferred.
    always_comb begin
        sel_psum = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            sel_psum = sel_psum | (i_Psum[b*BIT_PSUM +: BIT_PSUM] & {BIT_PSUM{i_Psram_En[b]}});
        end
    end

    assign multi_hot = |(i_Psram_En & (i_Psram_En - NUM_BANK'(1)));
    assign multi_set = i_Valid_WB_Psum && multi_hot;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_psum  <= '0;
            s1_mode  <= WB_MODE_SAT;
            s1_shift <= '0;
        end else begin
            s1_valid <= i_Valid_WB_Psum;
            if (i_Valid_WB_Psum) begin
                s1_psum  <= sel_psum;
                s1_mode  <= i_Mode;
                s1_shift <= i_Shift;
            end
        end
    end

    // Requantise the captured beat; mode 11 behaves as plain shift+saturate.
    always_comb begin
        shifted = $signed(s1_psum) >>> s1_shift;
        if (s1_mode == WB_MODE_RELU && shifted[BIT_PSUM-1]) begin
            shifted = '0;
        end
        if (s1_mode == WB_MODE_RAW) begin
            wb_data = s1_psum[BIT_OUT-1:0];
        end else begin
            wb_data = BIT_OUT'(saturate(WB_SAT_W'(shifted), BIT_OUT));
        end
    end

    psum_wb_fifo #(
        .DATA_W (BIT_OUT),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_Push  (s1_valid),
        .i_Pop   (pop),
        .i_Data  (wb_data),
        .o_Data  (o_Data_WB_Out),
        .o_Count (fifo_count),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty)
    );

    assign o_Valid_WB_Psum = !fifo_empty;
    assign pop             = o_Valid_WB_Psum && i_Ready;
    assign push_acc        = s1_valid && (!fifo_full || pop);
    assign ovf_set         = s1_valid && fifo_full && !pop;

    // Registered from next-state values so the flag reflects held plus in-flight beats.
    assign count_nxt = fifo_count + CW'(push_acc) - CW'(pop);
    assign af_nxt    = (32'(count_nxt) + 32'(i_Valid_WB_Psum)) >= 32'(DEPTH - 2);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_Almost_Full <= 1'b0;
            o_Err_Multi   <= 1'b0;
            o_Err_Ovf     <= 1'b0;
            o_Beat_Cnt    <= '0;
        end else begin
            o_Almost_Full <= af_nxt;
            o_Err_Multi   <= multi_set || (o_Err_Multi && !i_Err_Clr);
            o_Err_Ovf     <= ovf_set || (o_Err_Ovf && !i_Err_Clr);
            if (pop) begin
                o_Beat_Cnt <= o_Beat_Cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_psum_wb_buf.sv
// Self-checking bench for psum_wb_buf: directed scenarios plus randomized traffic
// compared against a transaction-level model (expected-value queue).
module tb_psum_wb_buf;

    localparam int NB    = 32;
    localparam int BP    = 32;
    localparam int BO    = 16;
    localparam int DEPTH = 8;
    localparam int BS    = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic [NB*BP-1:0] i_Psum;
    logic [NB-1:0]    i_Psram_En;
    logic             i_Valid_WB_Psum;
    logic [1:0]       i_Mode;
    logic [BS-1:0]    i_Shift;
    logic             o_Almost_Full;
    logic [BO-1:0]    o_Data_WB_Out;
    logic             o_Valid_WB_Psum;
    logic             i_Ready;
    logic             i_Err_Clr;
    logic             o_Err_Multi;
    logic             o_Err_Ovf;
    logic [15:0]      o_Beat_Cnt;

    psum_wb_buf #(
        .NUM_BANK (NB), .BIT_PSUM (BP), .BIT_OUT (BO), .DEPTH (DEPTH), .BIT_SHIFT (BS)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .i_Psum          (i_Psum),
        .i_Psram_En      (i_Psram_En),
        .i_Valid_WB_Psum (i_Valid_WB_Psum),
        .i_Mode          (i_Mode),
        .i_Shift         (i_Shift),
        .o_Almost_Full   (o_Almost_Full),
        .o_Data_WB_Out   (o_Data_WB_Out),
        .o_Valid_WB_Psum (o_Valid_WB_Psum),
        .i_Ready         (i_Ready),
        .i_Err_Clr       (i_Err_Clr),
        .o_Err_Multi     (o_Err_Multi),
        .o_Err_Ovf       (o_Err_Ovf),
        .o_Beat_Cnt      (o_Beat_Cnt)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Model: buffered words in order, the beat in flight, flags and counter.
    logic [15:0] exp_q[$];
    bit          pend_v;
    logic [15:0] pend_d;
    logic [15:0] m_cnt;
    bit          m_multi;
    bit          m_ovf;
    bit          m_af;

    function automatic logic [15:0] ref_out(input logic [NB*BP-1:0] ps, input logic [NB-1:0] en,
                                            input logic [1:0] mode, input logic [BS-1:0] sh);
        logic [31:0] sel;
        longint      v;
        sel = '0;
        for (int b = 0; b < NB; b++) if (en[b]) sel = sel | ps[b*BP +: BP];
        if (mode == 2'b10) return sel[15:0];
        v = longint'($signed(sel));
        v = v >>> sh;
        if (mode == 2'b01 && v < 0) v = 0;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    function automatic logic [15:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend_v  = 1'b0;
        pend_d  = '0;
        m_cnt   = '0;
        m_multi = 1'b0;
        m_ovf   = 1'b0;
        m_af    = 1'b0;
    endtask

    // Advance one clock and apply the same edge to the model, then settle.
    task automatic step();
        int sz;
        bit pop;
        bit ovf_set;
        @(posedge CLK);
        sz      = exp_q.size();
        pop     = (sz > 0) && i_Ready;
        ovf_set = 1'b0;
        if (pop) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (pend_v) begin
            if (sz < DEPTH || pop) exp_q.push_back(pend_d);
            else ovf_set = 1'b1;
        end
        m_ovf   = ovf_set || (m_ovf && !i_Err_Clr);
        m_multi = (i_Valid_WB_Psum && $countones(i_Psram_En) > 1) || (m_multi && !i_Err_Clr);
        pend_v  = i_Valid_WB_Psum;
        if (i_Valid_WB_Psum) pend_d = ref_out(i_Psum, i_Psram_En, i_Mode, i_Shift);
        m_af = (exp_q.size() + int'(pend_v)) >= DEPTH - 2;
        #1;
    endtask

    task automatic rand_beat(output logic [15:0] exp_v);
        for (int b = 0; b < NB; b++) i_Psum[b*BP +: BP] = $urandom;
        i_Psram_En      = NB'(1) << $urandom_range(0, NB - 1);
        i_Mode          = 2'($urandom_range(0, 3));
        i_Shift         = BS'($urandom_range(0, 31));
        i_Valid_WB_Psum = 1'b1;
        exp_v = ref_out(i_Psum, i_Psram_En, i_Mode, i_Shift);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        i_Psum = '0; i_Psram_En = '0; i_Valid_WB_Psum = 1'b0; i_Mode = 2'b00;
        i_Shift = '0; i_Ready = 1'b0; i_Err_Clr = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++; if (o_Valid_WB_Psum !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_Valid_WB_Psum); end
        n_vec++; if (o_Data_WB_Out !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", o_Data_WB_Out); end
        n_vec++; if (o_Almost_Full !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b want 0", o_Almost_Full); end
        n_vec++; if (o_Err_Multi !== 1'b0 || o_Err_Ovf !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b%b want 00", o_Err_Multi, o_Err_Ovf); end
        n_vec++; if (o_Beat_Cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", o_Beat_Cnt); end
        #2 RST = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        i_Psum = '0;
        i_Psum[5*BP +: BP] = 32'h0001_2340;
        i_Psram_En = 32'h20; i_Mode = 2'b00; i_Shift = 5'd4; i_Valid_WB_Psum = 1'b1;
        step();
        i_Valid_WB_Psum = 1'b0;
        n_vec++; if (o_Valid_WB_Psum !== 1'b0) begin n_err++; $display("FAIL single_cycle1_valid: got %b want 0", o_Valid_WB_Psum); end
        step();
        n_vec++; if (o_Valid_WB_Psum !== 1'b1) begin n_err++; $display("FAIL single_cycle2_valid: got %b want 1", o_Valid_WB_Psum); end
        n_vec++; if (o_Data_WB_Out !== 16'h1234) begin n_err++; $display("FAIL single_data: got %h want 1234", o_Data_WB_Out); end
        n_vec++; if (o_Data_WB_Out !== exp_head()) begin n_err++; $display("FAIL single_model: got %h want %h", o_Data_WB_Out, exp_head()); end
        i_Ready = 1'b1;
        step();
        i_Ready = 1'b0;
        n_vec++; if (o_Beat_Cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", o_Beat_Cnt); end
        n_vec++; if (o_Valid_WB_Psum !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b want 0", o_Valid_WB_Psum); end
    endtask

    task automatic test_sat_relu();
        logic [31:0] val  [4] = '{32'h0010_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'h8000_0000};
        logic [1:0]  mode [4] = '{2'b00, 2'b01, 2'b00, 2'b11};
        logic [4:0]  sh   [4] = '{5'd0, 5'd0, 5'd4, 5'd0};
        logic [15:0] want [4] = '{16'h7FFF, 16'h0000, 16'hFFF0, 16'h8000};
        for (int i = 0; i < 4; i++) begin
            i_Psum = '0;
            i_Psum[BP-1:0] = val[i];
            i_Psram_En = 32'h1; i_Mode = mode[i]; i_Shift = sh[i]; i_Valid_WB_Psum = 1'b1;
            step();
            i_Valid_WB_Psum = 1'b0;
            step();
            n_vec++; if (o_Data_WB_Out !== want[i]) begin n_err++; $display("FAIL sat_case%0d: got %h want %h", i, o_Data_WB_Out, want[i]); end
            i_Ready = 1'b1;
            step();
            i_Ready = 1'b0;
        end
    endtask

    task automatic test_multi_hot();
        i_Psum = '0;
        i_Psum[0 +: BP]  = 32'h0F;
        i_Psum[BP +: BP] = 32'hF0;
        i_Psram_En = 32'h3; i_Mode = 2'b10; i_Shift = 5'd7; i_Valid_WB_Psum = 1'b1;
        step();
        i_Valid_WB_Psum = 1'b0;
        n_vec++; if (o_Err_Multi !== 1'b1) begin n_err++; $display("FAIL multi_set: got %b want 1", o_Err_Multi); end
        step();
        n_vec++; if (o_Data_WB_Out !== 16'h00FF) begin n_err++; $display("FAIL multi_data: got %h want 00ff", o_Data_WB_Out); end
        i_Ready = 1'b1;
        step();
        i_Ready = 1'b0;
        n_vec++; if (o_Err_Multi !== 1'b1) begin n_err++; $display("FAIL multi_sticky: got %b want 1", o_Err_Multi); end
        i_Err_Clr = 1'b1;
        step();
        i_Err_Clr = 1'b0;
        n_vec++; if (o_Err_Multi !== 1'b0) begin n_err++; $display("FAIL multi_clear: got %b want 0", o_Err_Multi); end
        i_Psum = '1; i_Psram_En = '0; i_Mode = 2'b00; i_Shift = 5'd0; i_Valid_WB_Psum = 1'b1;
        step();
        i_Valid_WB_Psum = 1'b0;
        step();
        n_vec++; if (o_Valid_WB_Psum !== 1'b1 || o_Data_WB_Out !== 16'h0) begin n_err++; $display("FAIL zero_en_data: got v=%b %h want v=1 0000", o_Valid_WB_Psum, o_Data_WB_Out); end
        n_vec++; if (o_Err_Multi !== 1'b0) begin n_err++; $display("FAIL zero_en_err: got %b want 0", o_Err_Multi); end
        i_Ready = 1'b1;
        step();
        i_Ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] saved[$];
        logic [15:0] e;
        i_Ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rand_beat(e);
            saved.push_back(e);
            step();
            n_vec++; if (o_Almost_Full !== (i + 1 >= 6)) begin n_err++; $display("FAIL bp_af_edge%0d: got %b want %b", i + 1, o_Almost_Full, (i + 1 >= 6)); end
        end
        i_Valid_WB_Psum = 1'b0;
        step();
        n_vec++; if (o_Err_Ovf !== 1'b1) begin n_err++; $display("FAIL bp_ovf: got %b want 1", o_Err_Ovf); end
        n_vec++; if (o_Err_Ovf !== m_ovf || o_Almost_Full !== m_af) begin n_err++; $display("FAIL bp_model_flags: got ovf=%b af=%b want ovf=%b af=%b", o_Err_Ovf, o_Almost_Full, m_ovf, m_af); end
        step();
        n_vec++; if (o_Data_WB_Out !== saved[0]) begin n_err++; $display("FAIL bp_hold: got %h want %h", o_Data_WB_Out, saved[0]); end
        i_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (o_Valid_WB_Psum !== 1'b1 || o_Data_WB_Out !== saved[i]) begin n_err++; $display("FAIL bp_drain%0d: got v=%b %h want v=1 %h", i, o_Valid_WB_Psum, o_Data_WB_Out, saved[i]); end
            step();
        end
        n_vec++; if (o_Valid_WB_Psum !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", o_Valid_WB_Psum); end
        i_Ready = 1'b0;
        i_Err_Clr = 1'b1;
        step();
        i_Err_Clr = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [15:0] saved[$];
        logic [15:0] e;
        i_Ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rand_beat(e);
            saved.push_back(e);
            step();
        end
        i_Valid_WB_Psum = 1'b0;
        step();
        rand_beat(e);
        saved.push_back(e);
        step();
        i_Valid_WB_Psum = 1'b0;
        i_Ready = 1'b1;
        step();
        n_vec++; if (o_Err_Ovf !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf: got %b want 0", o_Err_Ovf); end
        n_vec++; if (o_Almost_Full !== 1'b1) begin n_err++; $display("FAIL fullpop_af: got %b want 1", o_Almost_Full); end
        for (int i = 1; i < 9; i++) begin
            n_vec++; if (o_Valid_WB_Psum !== 1'b1 || o_Data_WB_Out !== saved[i]) begin n_err++; $display("FAIL fullpop_drain%0d: got v=%b %h want v=1 %h", i, o_Valid_WB_Psum, o_Data_WB_Out, saved[i]); end
            step();
        end
        n_vec++; if (o_Valid_WB_Psum !== 1'b0) begin n_err++; $display("FAIL fullpop_empty: got %b want 0", o_Valid_WB_Psum); end
        i_Ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        i_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_beat(e);
            step();
        end
        i_Valid_WB_Psum = 1'b0;
        step();
        n_vec++; if (o_Valid_WB_Psum !== 1'b1) begin n_err++; $display("FAIL mid_prefill: got %b want 1", o_Valid_WB_Psum); end
        #2 RST = 1'b1;
        #1;
        n_vec++; if (o_Valid_WB_Psum !== 1'b0 || o_Data_WB_Out !== 16'h0) begin n_err++; $display("FAIL mid_rst_out: got v=%b %h want v=0 0000", o_Valid_WB_Psum, o_Data_WB_Out); end
        n_vec++; if (o_Beat_Cnt !== 16'h0 || o_Almost_Full !== 1'b0 || o_Err_Multi !== 1'b0 || o_Err_Ovf !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_status: got cnt=%0d af=%b em=%b eo=%b want all 0", o_Beat_Cnt, o_Almost_Full, o_Err_Multi, o_Err_Ovf);
        end
        model_reset();
        @(posedge CLK);
        #3 RST = 1'b0;
        rand_beat(e);
        step();
        i_Valid_WB_Psum = 1'b0;
        n_vec++; if (o_Valid_WB_Psum !== 1'b0) begin n_err++; $display("FAIL mid_after_c1: got %b want 0", o_Valid_WB_Psum); end
        step();
        n_vec++; if (o_Valid_WB_Psum !== 1'b1 || o_Data_WB_Out !== e) begin n_err++; $display("FAIL mid_after_c2: got v=%b %h want v=1 %h", o_Valid_WB_Psum, o_Data_WB_Out, e); end
        i_Ready = 1'b1;
        step();
        i_Ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NB; b++) begin
                logic [31:0] v;
                v = $urandom;
                if ($urandom_range(0, 1) == 1) v = $signed(v) >>> $urandom_range(0, 31);
                i_Psum[b*BP +: BP] = v;
            end
            case ($urandom_range(0, 9))
                0:       i_Psram_En = '0;
                1:       i_Psram_En = $urandom;
                default: i_Psram_En = NB'(1) << $urandom_range(0, NB - 1);
            endcase
            i_Valid_WB_Psum = ($urandom_range(0, 3) != 0);
            i_Mode          = 2'($urandom_range(0, 3));
            i_Shift         = BS'($urandom_range(0, 31));
            i_Ready         = ($urandom_range(0, 2) != 0);
            i_Err_Clr       = ($urandom_range(0, 15) == 0);
            step();
            n_vec++; if (o_Valid_WB_Psum !== (exp_q.size() > 0) || o_Data_WB_Out !== exp_head()) begin
                n_err++; $display("FAIL rand_head c%0d: got v=%b %h want v=%b %h", c, o_Valid_WB_Psum, o_Data_WB_Out, exp_q.size() > 0, exp_head());
            end
            n_vec++; if (o_Almost_Full !== m_af) begin n_err++; $display("FAIL rand_af c%0d: got %b want %b", c, o_Almost_Full, m_af); end
            n_vec++; if (o_Err_Multi !== m_multi || o_Err_Ovf !== m_ovf) begin
                n_err++; $display("FAIL rand_err c%0d: got em=%b eo=%b want em=%b eo=%b", c, o_Err_Multi, o_Err_Ovf, m_multi, m_ovf);
            end
            n_vec++; if (o_Beat_Cnt !== m_cnt) begin n_err++; $display("FAIL rand_cnt c%0d: got %0d want %0d", c, o_Beat_Cnt, m_cnt); end
        end
        i_Valid_WB_Psum = 1'b0;
        i_Err_Clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_sat_relu();
        test_multi_hot();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/psum_wb_buf.md
Name: psum_wb_buf

Overview:
Parametrised partial-sum writeback stage between the PE-column psum banks and the output SRAM/DMA path.
- Selects one bank per beat using a one-hot enable.
- Optionally requantises the value: arithmetic shift, ReLU, signed saturation.
- Buffers results in a small first-word-fall-through (FWFT) FIFO and drains them over a valid/ready handshake.
- Provides backpressure and sticky error reporting.

Parameters:
NUM_BANK, 32, number of psum banks / PE columns
BIT_PSUM, 32, width of each bank psum (signed two's complement)
BIT_OUT, 16, width of the written-back word
DEPTH, 8, FIFO entries (power of two, >=4)
BIT_SHIFT, 5, width of shift amount

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
i_Psum  in  NUM_BANK*BIT_PSUM  flattened banks, bank b at [b*BIT_PSUM +: BIT_PSUM]
i_Psram_En  in  NUM_BANK  bank select, one-hot expected
i_Valid_WB_Psum  in  1  beat present this cycle
i_Mode  in  2  00 shift+sat, 01 shift+ReLU+sat, 10 raw (low BIT_OUT bits), 11 = 00
i_Shift  in  BIT_SHIFT  arithmetic right-shift amount
o_Almost_Full  out  1  upstream must stop issuing beats
o_Data_WB_Out  out  BIT_OUT  FIFO head data
o_Valid_WB_Psum  out  1  FIFO non-empty
i_Ready  in  1  downstream accepts head
i_Err_Clr  in  1  clears sticky errors
o_Err_Multi  out  1  sticky: multi-hot enable seen on a valid beat
o_Err_Ovf  out  1  sticky: push attempted on full FIFO
o_Beat_Cnt  out  16  accepted output beats, wraps at 2^16

Behaviour:
- Reset: FIFO empty. All outputs 0: o_Valid_WB_Psum, o_Data_WB_Out, o_Almost_Full, both error flags, o_Beat_Cnt. Pipeline valids cleared. A beat in flight during reset is discarded.
- Stage 1 (edge k): if i_Valid_WB_Psum, register the selected psum plus i_Mode and i_Shift. Mode and shift are sampled per beat.
  - Selection = OR over banks of (bank AND its enable bit).
  - En == 0: selects zero.
  - Multi-hot: OR of the selected banks, and o_Err_Multi is set.
- Stage 2 (combinational, written to the FIFO at edge k+1):
  - Arithmetic right shift by i_Shift.
  - If mode 01 and the result is negative, force 0.
  - Modes 00/01: clamp to [-2^(BIT_OUT-1), 2^(BIT_OUT-1)-1].
  - Mode 10: no shift, no clamp; low BIT_OUT bits taken.
- Latency: beat presented in cycle 0 (sampled at edge 1) appears on o_Valid_WB_Psum / o_Data_WB_Out in cycle 2 when the FIFO was empty.
- Output handshake:
  - Head pops when o_Valid_WB_Psum && i_Ready.
  - o_Data_WB_Out holds stable while o_Valid_WB_Psum is high and i_Ready is low.
  - o_Beat_Cnt increments on each pop.
- o_Almost_Full is registered, high when (count + stage1 valid) >= DEPTH-2. This absorbs the in-flight beat plus the one-cycle reaction of upstream.
- Push on full:
  - With a pop in the same cycle: the push is accepted and the count is unchanged.
  - Without a pop: the beat is dropped and o_Err_Ovf is set.
- Simultaneous push and pop on an empty FIFO: no pop occurs (valid low); the push lands.
- Error flags are sticky. i_Err_Clr clears them, but a same-cycle set wins over clear.
- Count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

Decomposition:
- Shared package psum_wb_pkg:
  - mode constants WB_MODE_SAT, WB_MODE_RELU, WB_MODE_RAW
  - a saturate(value, BIT_OUT) function
  - default widths
- One sub-module, psum_wb_fifo: parametrised FWFT sync FIFO with count, full, empty and async active-high reset.

Test Plan:
- Single beat, BIT_PSUM=32, BIT_OUT=16: En=0x20, bank5=0x00012340, mode 00, shift 4 -> o_Data=0x1234, valid in cycle 2, o_Beat_Cnt=1 after pop.
- Saturation / ReLU, all shift 0 except the last:
  - bank0=0x00100000, mode 00 -> 0x7FFF.
  - bank0=0xFFFFFF00, mode 01 -> 0x0000.
  - bank0=0xFFFFFF00, mode 00, shift 4 -> 0xFFF0.
- Multi-hot: En=0x3, bank0=0x0F, bank1=0xF0, mode 10 -> 0x00FF; o_Err_Multi=1 until i_Err_Clr. En=0 with valid -> 0x0000, no error.
- Backpressure, i_Ready=0, DEPTH=8:
  - 8 back-to-back beats -> o_Almost_Full rises once 6 are held/in flight.
  - 9th beat -> dropped, o_Err_Ovf=1.
  - Raise i_Ready -> first 8 values drain in order.
- Full with concurrent pop: FIFO full, i_Ready=1, new beat arrives -> beat accepted, count stays 8, no o_Err_Ovf.
- Reset mid-stream: assert RST asynchronously with 3 entries buffered -> all outputs 0 immediately; after release the first new beat appears 2 cycles after it is presented.
